noc_router: RTL and testbench

Five-port (East, West, North, South, local PE) wormhole router for a 2D-mesh network-on-chip. Each input port has a flit FIFO and a per-port control FSM (IDLE → RCU → SA → ST). The FSM computes a dimension-ordered (XY) route from the header flit, arbitrates for the output port, and streams the packet through the crossbar until its tail flit leaves. One instance sits at each mesh node, between four neighbour routers and one processing element.

---
 rtl/noc_router.sv | 219 +++++++++++++++++++++
 tb/tb_noc_router.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/noc_router.sv
// rtl/noc_router.sv - 5-port XY wormhole mesh router with per-input FIFO and IDLE/RCU/SA/ST control
// Define NOC_ROUTER_ARB_FIXED_EN for fixed-priority (E>W>N>S>PE) output arbitration instead of round-robin.
module noc_router #(
  parameter logic [3:0] X_ADDR = 4'd1,
  parameter logic [3:0] Y_ADDR = 4'd2,
  parameter int         DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [39:0] flit_in_e,
  input  logic [39:0] flit_in_w,
  input  logic [39:0] flit_in_n,
  input  logic [39:0] flit_in_s,
  input  logic [39:0] flit_in_pe,
  output logic [39:0] do_e,
  output logic [39:0] do_w,
  output logic [39:0] do_n,
  output logic [39:0] do_s,
  output logic [39:0] do_pe,
  input  logic        req_in_e,
  input  logic        req_in_w,
  input  logic        req_in_s,
  input  logic        req_in_n,
  input  logic        req_in_pe,
  input  logic        grnt_in_e,
  input  logic        grnt_in_w,
  input  logic        grnt_in_n,
  input  logic        grnt_in_s,
  input  logic        grnt_in_pe,
  output logic        grantfe,
  output logic        grantfw,
  output logic        grantfn,
  output logic        grantfs,
  output logic        grantfl,
  output logic        req_out_e,
  output logic        req_out_w,
  output logic        req_out_s,
  output logic        req_out_n
);
  localparam int          NP       = 5;
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [1:0]  T_HEAD   = 2'b11;
  localparam logic [1:0]  T_TAIL   = 2'b01;
  localparam logic [1:0]  T_NULL   = 2'b00;

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    RCU  = 4'b0010,
    SA   = 4'b0100,
    ST   = 4'b1000
  } state_t;

  // Port index order everywhere: 0=E, 1=W, 2=N, 3=S, 4=PE
  logic [39:0]   flit_in [NP];
  logic [NP-1:0] req_in, grnt_in;
  logic [39:0]   head [NP];
  logic [NP-1:0] full, empty, wr_en, rd_en;
  state_t        state [NP];
  state_t        state_nxt [NP];
  logic [2:0]    route [NP];
  logic [2:0]    calc_route [NP];
  logic [NP-1:0] grant [NP];
  logic [2:0]    win [NP];
  logic [NP-1:0] locked, rel;
  logic [2:0]    owner [NP];
  logic [39:0]   out_flit [NP];
  logic          found;
  logic [2:0]    idx;
`ifndef NOC_ROUTER_ARB_FIXED_EN
  logic [2:0]    rr_ptr [NP];
`endif

  assign flit_in[0] = flit_in_e;
  assign flit_in[1] = flit_in_w;
  assign flit_in[2] = flit_in_n;
  assign flit_in[3] = flit_in_s;
  assign flit_in[4] = flit_in_pe;
  assign req_in  = {req_in_pe, req_in_s, req_in_n, req_in_w, req_in_e};
  assign grnt_in = {grnt_in_pe, grnt_in_s, grnt_in_n, grnt_in_w, grnt_in_e};
  assign {grantfl, grantfs, grantfn, grantfw, grantfe} = {NP{rst}} & ~full;

  for (genvar i = 0; i < NP; i++) begin : g_fifo
    logic [39:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    // A full FIFO refuses writes even when a pop happens in the same cycle
    assign full[i]  = (count == FULL_CNT);
    assign empty[i] = (count == '0);
    assign wr_en[i] = req_in[i] && !full[i] && (flit_in[i][39:38] != T_NULL);
    assign head[i]  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_en[i]) wr_ptr <= wr_ptr + AW'(1);
        if (rd_en[i]) rd_ptr <= rd_ptr + AW'(1);
        case ({wr_en[i], rd_en[i]})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (wr_en[i]) mem[wr_ptr] <= flit_in[i];
    end
  end

  // Dimension-ordered routing: resolve X first, then Y, else eject to the PE
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      if (head[i][29:26] > X_ADDR)      calc_route[i] = 3'd0;
      else if (head[i][29:26] < X_ADDR) calc_route[i] = 3'd1;
      else if (head[i][25:22] > Y_ADDR) calc_route[i] = 3'd2;
      else if (head[i][25:22] < Y_ADDR) calc_route[i] = 3'd3;
      else                              calc_route[i] = 3'd4;
    end
  end

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int o = 0; o < NP; o++) begin
      grant[o] = '0;
      win[o]   = '0;
      found    = 1'b0;
      for (int k = 0; k < NP; k++) begin
`ifdef NOC_ROUTER_ARB_FIXED_EN
        idx = 3'(k);
`else
        idx = 3'((int'(rr_ptr[o]) + k) % NP);
`endif
        if (!locked[o] && !found && state[idx] == SA && route[idx] == 3'(o)) begin
          found          = 1'b1;
          grant[o][idx]  = 1'b1;
          win[o]         = idx;
        end
      end
    end
  end

  always_comb begin
    rd_en = '0;
    rel   = '0;
    for (int i = 0; i < NP; i++) begin
      state_nxt[i] = state[i];
      case (state[i])
        IDLE: if (!empty[i]) begin
          if (head[i][39:38] == T_HEAD) state_nxt[i] = RCU;
          else                          rd_en[i]     = 1'b1;
        end
        RCU:  state_nxt[i] = SA;
        SA:   if (grant[route[i]][i]) state_nxt[i] = ST;
        ST:   if (!empty[i] && grnt_in[route[i]]) begin
          rd_en[i] = 1'b1;
          if (head[i][39:38] == T_TAIL) begin
            state_nxt[i]  = IDLE;
            rel[route[i]] = 1'b1;
          end
        end
        default: state_nxt[i] = IDLE;
      endcase
    end
  end

  // Only the lock owner can be in ST on an output, so the crossbar is a select by owner
  always_comb begin
    for (int o = 0; o < NP; o++) begin
      out_flit[o] = '0;
      if (locked[o] && state[owner[o]] == ST && !empty[owner[o]]) out_flit[o] = head[owner[o]];
    end
  end

  assign do_e      = out_flit[0];
  assign do_w      = out_flit[1];
  assign do_n      = out_flit[2];
  assign do_s      = out_flit[3];
  assign do_pe     = out_flit[4];
  assign req_out_e = |out_flit[0][39:38];
  assign req_out_w = |out_flit[1][39:38];
  assign req_out_n = |out_flit[2][39:38];
  assign req_out_s = |out_flit[3][39:38];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      locked <= '0;
      for (int i = 0; i < NP; i++) begin
        state[i] <= IDLE;
        route[i] <= '0;
        owner[i] <= '0;
`ifndef NOC_ROUTER_ARB_FIXED_EN
        rr_ptr[i] <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < NP; i++) begin
        state[i] <= state_nxt[i];
        if (state[i] == RCU) route[i] <= calc_route[i];
      end
      for (int o = 0; o < NP; o++) begin
        if (|grant[o]) begin
          locked[o] <= 1'b1;
          owner[o]  <= win[o];
`ifndef NOC_ROUTER_ARB_FIXED_EN
          rr_ptr[o] <= (win[o] == 3'd4) ? 3'd0 : win[o] + 3'd1;
`endif
        end else if (rel[o]) begin
          locked[o] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_noc_router.sv
// tb/tb_noc_router.sv - scoreboard bench for noc_router at mesh node (1,2)
module tb_noc_router;
  logic        clk = 1'b0;
  logic        rst;
  logic [39:0] fin [5];
  logic [39:0] dout [5];
  logic [4:0]  rin, gin, gf, rout;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          first_e = -1;
  int          wr_cyc = 0;
  logic [39:0] exp_q [5][$];
  logic [39:0] mon_exp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  noc_router #(.X_ADDR(4'd1), .Y_ADDR(4'd2), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .flit_in_e(fin[0]), .flit_in_w(fin[1]), .flit_in_n(fin[2]), .flit_in_s(fin[3]), .flit_in_pe(fin[4]),
    .do_e(dout[0]), .do_w(dout[1]), .do_n(dout[2]), .do_s(dout[3]), .do_pe(dout[4]),
    .req_in_e(rin[0]), .req_in_w(rin[1]), .req_in_s(rin[3]), .req_in_n(rin[2]), .req_in_pe(rin[4]),
    .grnt_in_e(gin[0]), .grnt_in_w(gin[1]), .grnt_in_n(gin[2]), .grnt_in_s(gin[3]), .grnt_in_pe(gin[4]),
    .grantfe(gf[0]), .grantfw(gf[1]), .grantfn(gf[2]), .grantfs(gf[3]), .grantfl(gf[4]),
    .req_out_e(rout[0]), .req_out_w(rout[1]), .req_out_s(rout[3]), .req_out_n(rout[2])
  );
  assign rout[4] = |dout[4][39:38];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [39:0] hdr(input logic [3:0] dx, input logic [3:0] dy, input logic [21:0] d);
    return {2'b11, 4'd1, 4'd2, dx, dy, d};
  endfunction
  function automatic logic [39:0] pay(input int d);
    return {2'b10, 38'(d)};
  endfunction
  function automatic logic [39:0] tl(input int d);
    return {2'b01, 38'(d)};
  endfunction

  task automatic put(input int p, input logic [39:0] f);
    fin[p] = f;
    rin[p] = 1'b1;
  endtask
  task automatic tick();
    @(negedge clk);
    rin = '0;
  endtask
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic check_drained(input string name);
    for (int p = 0; p < 5; p++) begin
      check($sformatf("%s_left_port%0d", name, p), 64'(exp_q[p].size()), 64'd0);
      exp_q[p].delete();
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midreset_grantf", 64'(gf), 64'd0);
    check("midreset_req_out", 64'(rout), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Monitor: every accepted output flit is popped from that port's expected queue
  always @(negedge clk) begin
    if (rst) begin
      for (int p = 0; p < 5; p++) begin
        if (rout[p] && gin[p]) begin
          if (p == 0 && first_e < 0) first_e = cyc;
          if (exp_q[p].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_flit port=%0d got=%h exp=none", p, dout[p]);
          end else begin
            mon_exp = exp_q[p].pop_front();
            check($sformatf("flit_port%0d", p), 64'(dout[p]), 64'(mon_exp));
          end
        end else if (!rout[p]) begin
          check($sformatf("idle_zero_port%0d", p), 64'(dout[p]), 64'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [39:0] h;
    rst = 1'b0;
    rin = '0;
    gin = 5'h1f;
    for (int p = 0; p < 5; p++) fin[p] = '0;
    #3;
    for (int p = 0; p < 5; p++) check($sformatf("reset_do%0d", p), 64'(dout[p]), 64'd0);
    check("reset_req_out", 64'(rout), 64'd0);
    check("reset_grantf", 64'(gf), 64'd0);
    #3;
    rst = 1'b1;
    @(negedge clk);
    check("grantf_after_reset", 64'(gf), 64'h1f);

    // Single packet E -> E (dst (3,10)), three cycles header latency
    first_e = -1;
    h = hdr(4'd3, 4'd10, 22'h12345);
    exp_q[0].push_back(h);
    exp_q[0].push_back(pay(32'h111));
    exp_q[0].push_back(tl(32'h222));
    put(0, h); tick();
    wr_cyc = cyc;
    put(0, pay(32'h111)); tick();
    put(0, tl(32'h222)); tick();
    wait_cycles(8);
    check("latency_e", 64'(first_e - wr_cyc), 64'd3);
    check_drained("single");

    // Five simultaneous packets all routed E, served in port order
    do_reset();
    for (int p = 0; p < 5; p++) begin
      exp_q[0].push_back(hdr(4'd3, 4'd10, 22'(p)));
      exp_q[0].push_back(pay(100 + p));
      exp_q[0].push_back(tl(200 + p));
    end
    for (int p = 0; p < 5; p++) put(p, hdr(4'd3, 4'd10, 22'(p)));
    tick();
    for (int p = 0; p < 5; p++) put(p, pay(100 + p));
    tick();
    for (int p = 0; p < 5; p++) put(p, tl(200 + p));
    tick();
    wait_cycles(30);
    check_drained("contention");

    // Local delivery: N input with dst (1,2) -> PE
    h = hdr(4'd1, 4'd2, 22'h3c3c3);
    exp_q[4].push_back(h);
    exp_q[4].push_back(pay(32'h333));
    exp_q[4].push_back(tl(32'h444));
    put(2, h); tick();
    put(2, pay(32'h333)); tick();
    put(2, tl(32'h444)); tick();
    wait_cycles(10);
    check_drained("to_pe");

    // Stray payload on idle S is discarded; S then routes dst (1,0) -> S
    put(3, pay(32'h555)); tick();
    wait_cycles(6);
    h = hdr(4'd1, 4'd0, 22'h00abc);
    exp_q[3].push_back(h);
    exp_q[3].push_back(tl(32'h666));
    put(3, h); tick();
    put(3, tl(32'h666)); tick();
    wait_cycles(10);
    check_drained("discard");

    // Fill W while E is back-pressured; the fifth write must be refused
    @(posedge clk);
    #1 gin[0] = 1'b0;
    @(negedge clk);
    h = hdr(4'd3, 4'd10, 22'h0f0f0);
    exp_q[0].push_back(h);
    exp_q[0].push_back(pay(32'h777));
    exp_q[0].push_back(pay(32'h888));
    exp_q[0].push_back(tl(32'h999));
    put(1, h); tick();
    put(1, pay(32'h777)); tick();
    put(1, pay(32'h888)); tick();
    put(1, tl(32'h999)); tick();
    check("grantfw_full", 64'(gf[1]), 64'd0);
    put(1, hdr(4'd1, 4'd2, 22'h1dead)); tick();
    check("grantfw_still_full", 64'(gf[1]), 64'd0);
    @(posedge clk);
    #1 gin[0] = 1'b1;
    wait_cycles(10);
    check("grantfw_drained", 64'(gf[1]), 64'd1);
    check_drained("full");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
